// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake and a two-entry skid buffer.
// Carries PC, payload, exception code and delay-slot flag; supports flush, exception and stall counting.
module pipe_stage_skid #(
   parameter int unsigned DATA_W  = 96,
   parameter int unsigned PC_W    = 32,
   parameter int unsigned EXC_W   = 5,
   parameter logic [31:0] EXC_VEC = 32'h0000_4180,
   parameter logic [31:0] CLR_PC  = 32'h0000_0000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic              in_ds,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exc,
   output logic              out_ds,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [PC_W-1:0] ExcPc = PC_W'(EXC_VEC);
   localparam logic [PC_W-1:0] ClrPc = PC_W'(CLR_PC);

   // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StMain  = 2'b01,
      StSkid  = 2'b11
   } state_e;

   state_e state_q, state_d;

   logic [PC_W-1:0]   main_pc_q;
   logic [DATA_W-1:0] main_data_q;
   logic [EXC_W-1:0]  main_exc_q;
   logic              main_ds_q;

   logic [PC_W-1:0]   skid_pc_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [EXC_W-1:0]  skid_exc_q;
   logic              skid_ds_q;

   logic [CNT_W-1:0]  stall_q, stall_d;

   logic in_hs, out_hs;
   logic ld_main_in, ld_main_skid, ld_skid;

   assign out_valid = state_q[0];
   assign in_ready  = ~state_q[1];
   assign out_pc    = main_pc_q;
   assign out_data  = main_data_q;
   assign out_exc   = main_exc_q;
   assign out_ds    = main_ds_q;
   assign stall_cnt = stall_q;

   assign in_hs  = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state_q)
         StEmpty: begin
            if (in_hs) begin
               ld_main_in = 1'b1;
               state_d    = StMain;
            end
         end
         StMain: begin
            if (in_hs && out_hs) begin
               ld_main_in = 1'b1;
            end else if (in_hs) begin
               ld_skid = 1'b1;
               state_d = StSkid;
            end else if (out_hs) begin
               state_d = StEmpty;
            end
         end
         StSkid: begin
            if (out_hs) begin
               ld_main_skid = 1'b1;
               state_d      = StMain;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StEmpty;
         main_pc_q   <= ClrPc;
         main_data_q <= '0;
         main_exc_q  <= '0;
         main_ds_q   <= 1'b0;
      end else if (req || flush) begin
         state_q     <= StEmpty;
         main_pc_q   <= req ? ExcPc : ClrPc;
         main_data_q <= '0;
         main_exc_q  <= '0;
         main_ds_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ld_main_in) begin
            main_pc_q   <= in_pc;
            main_data_q <= in_data;
            main_exc_q  <= in_exc;
            main_ds_q   <= in_ds;
         end else if (ld_main_skid) begin
            main_pc_q   <= skid_pc_q;
            main_data_q <= skid_data_q;
            main_exc_q  <= skid_exc_q;
            main_ds_q   <= skid_ds_q;
         end
      end
   end

   // Skid payload needs no reset: it is only observed after being loaded.
   always_ff @(posedge clk) begin
      if (ld_skid && !reset && !req && !flush) begin
         skid_pc_q   <= in_pc;
         skid_data_q <= in_data;
         skid_exc_q  <= in_exc;
         skid_ds_q   <= in_ds;
      end
   end

   // Counter holds across req/flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (!req && !flush) begin
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed stimulus pushes expected PCs, a monitor pops on
// every output handshake; a second instance with CNT_W=4 exercises counter saturation.
module tb_pipe_stage_skid;

   logic         clk = 1'b0;
   logic         reset, flush, req;
   logic         in_valid, in_ready;
   logic [31:0]  in_pc;
   logic [95:0]  in_data;
   logic [4:0]   in_exc;
   logic         in_ds;
   logic         out_valid, out_ready;
   logic [31:0]  out_pc;
   logic [95:0]  out_data;
   logic [4:0]   out_exc;
   logic         out_ds;
   logic [15:0]  stall_cnt;

   logic         sat_reset, sat_in_valid, sat_in_ready, sat_out_valid, sat_out_ready;
   logic [31:0]  sat_out_pc;
   logic [95:0]  sat_out_data;
   logic [4:0]   sat_out_exc;
   logic         sat_out_ds;
   logic [3:0]   sat_stall;

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  mon_pc;

   always #5 clk = ~clk;

   pipe_stage_skid u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req       (req),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_data   (in_data),
      .in_exc    (in_exc),
      .in_ds     (in_ds),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_data  (out_data),
      .out_exc   (out_exc),
      .out_ds    (out_ds),
      .stall_cnt (stall_cnt)
   );

   pipe_stage_skid #(.CNT_W(4)) u_sat (
      .clk       (clk),
      .reset     (sat_reset),
      .flush     (1'b0),
      .req       (1'b0),
      .in_valid  (sat_in_valid),
      .in_ready  (sat_in_ready),
      .in_pc     (32'h0000_5000),
      .in_data   (96'h1),
      .in_exc    (5'h1),
      .in_ds     (1'b0),
      .out_valid (sat_out_valid),
      .out_ready (sat_out_ready),
      .out_pc    (sat_out_pc),
      .out_data  (sat_out_data),
      .out_exc   (sat_out_exc),
      .out_ds    (sat_out_ds),
      .stall_cnt (sat_stall)
   );

   function automatic logic [95:0] mk_data(input logic [31:0] pc);
      return {pc, ~pc, pc ^ 32'hA5A5_A5A5};
   endfunction

   function automatic logic [4:0] mk_exc(input logic [31:0] pc);
      return pc[6:2];
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; handshakes are judged at the negedge, before the posedge commits them.
   task automatic step(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic rst, input logic rq, input logic fl);
      reset     = rst;
      req       = rq;
      flush     = fl;
      in_valid  = v;
      in_pc     = pc;
      in_data   = mk_data(pc);
      in_exc    = mk_exc(pc);
      in_ds     = pc[2];
      out_ready = ordy;
      @(negedge clk);
      if (v && in_ready && !rst && !rq && !fl) exp_q.push_back(pc);
      @(posedge clk);
      #1;
      if (rst || rq || fl) exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready && !reset && !req && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got pc %0h expected no entry", out_pc);
         end else begin
            mon_pc = exp_q.pop_front();
            check("mon_pc", 128'(out_pc), 128'(mon_pc));
            check("mon_data", 128'(out_data), 128'(mk_data(mon_pc)));
            check("mon_exc", 128'(out_exc), 128'(mk_exc(mon_pc)));
            check("mon_ds", 128'(out_ds), 128'(mon_pc[2]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      sat_reset     = 1'b1;
      sat_in_valid  = 1'b0;
      sat_out_ready = 1'b0;
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_pc", 128'(out_pc), 128'(0));
      check("rst_stall", 128'(stall_cnt), 128'(0));
      sat_reset = 1'b0;

      // Fill main and skid, then reset while holding two entries.
      step(1, 32'h100, 0, 0, 0, 0);
      step(1, 32'h104, 0, 0, 0, 0);
      check("fill_in_ready", 128'(in_ready), 128'(0));
      check("fill_stall", 128'(stall_cnt), 128'(1));
      step(0, 0, 0, 1, 0, 0);
      check("rst2_out_valid", 128'(out_valid), 128'(0));
      check("rst2_in_ready", 128'(in_ready), 128'(1));
      check("rst2_out_pc", 128'(out_pc), 128'(0));
      check("rst2_out_data", 128'(out_data), 128'(0));
      check("rst2_stall", 128'(stall_cnt), 128'(0));

      // Streaming at full throughput.
      step(1, 32'h3000, 1, 0, 0, 0);
      check("str0_pc", 128'(out_pc), 128'(32'h3000));
      check("str0_in_ready", 128'(in_ready), 128'(1));
      step(1, 32'h3004, 1, 0, 0, 0);
      check("str1_pc", 128'(out_pc), 128'(32'h3004));
      step(1, 32'h3008, 1, 0, 0, 0);
      check("str2_pc", 128'(out_pc), 128'(32'h3008));
      check("str2_valid", 128'(out_valid), 128'(1));
      step(0, 0, 1, 0, 0, 0);
      check("drain_valid", 128'(out_valid), 128'(0));
      check("drain_pc_kept", 128'(out_pc), 128'(32'h3008));
      check("str_stall", 128'(stall_cnt), 128'(0));

      // Back-pressure: second entry lands in skid, three stalled cycles.
      step(1, 32'h3000, 0, 0, 0, 0);
      step(1, 32'h3004, 0, 0, 0, 0);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("bp_stall", 128'(stall_cnt), 128'(3));
      check("bp_pc_main", 128'(out_pc), 128'(32'h3000));
      step(0, 0, 1, 0, 0, 0);
      check("bp_pc_skid", 128'(out_pc), 128'(32'h3004));
      check("bp_in_ready2", 128'(in_ready), 128'(1));
      check("bp_stall_hold", 128'(stall_cnt), 128'(3));
      step(0, 0, 1, 0, 0, 0);
      check("bp_empty", 128'(out_valid), 128'(0));

      // Exception request with a full skid and an offered entry.
      step(1, 32'h3100, 0, 0, 0, 0);
      step(1, 32'h3104, 0, 0, 0, 0);
      check("req_pre_in_ready", 128'(in_ready), 128'(0));
      step(1, 32'h3010, 1, 0, 1, 0);
      check("req_pc", 128'(out_pc), 128'(32'h4180));
      check("req_valid", 128'(out_valid), 128'(0));
      check("req_exc", 128'(out_exc), 128'(0));
      check("req_ds", 128'(out_ds), 128'(0));
      check("req_data", 128'(out_data), 128'(0));
      check("req_in_ready", 128'(in_ready), 128'(1));
      check("req_stall", 128'(stall_cnt), 128'(4));
      step(0, 0, 1, 0, 0, 0);
      check("req_idle_valid", 128'(out_valid), 128'(0));

      // Input handshake coinciding with flush is dropped.
      step(1, 32'h3020, 1, 0, 0, 1);
      check("fl_hs_valid", 128'(out_valid), 128'(0));
      check("fl_hs_pc", 128'(out_pc), 128'(0));
      step(0, 0, 1, 0, 0, 0);
      check("fl_idle_valid", 128'(out_valid), 128'(0));

      // req and flush together: req wins.
      step(1, 32'h3200, 1, 0, 0, 0);
      check("rf_pre_pc", 128'(out_pc), 128'(32'h3200));
      step(0, 0, 1, 0, 1, 1);
      check("rf_pc", 128'(out_pc), 128'(32'h4180));
      check("rf_valid", 128'(out_valid), 128'(0));
      check("rf_stall", 128'(stall_cnt), 128'(4));
      step(1, 32'h3204, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      check("fl_pc", 128'(out_pc), 128'(0));
      check("fl_valid", 128'(out_valid), 128'(0));
      check("fl_stall", 128'(stall_cnt), 128'(4));

      // Saturation on the 4-bit instance.
      sat_in_valid = 1'b1;
      step(0, 0, 1, 0, 0, 0);
      sat_in_valid = 1'b0;
      repeat (14) step(0, 0, 1, 0, 0, 0);
      check("sat_14", 128'(sat_stall), 128'(14));
      repeat (6) step(0, 0, 1, 0, 0, 0);
      check("sat_15", 128'(sat_stall), 128'(15));
      check("sat_valid", 128'(sat_out_valid), 128'(1));
      check("sat_pc", 128'(sat_out_pc), 128'(32'h5000));

      check("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
